// File: rtl/core_l3_arbiter_pkg.sv
// Constants shared by the cores, the L3 grid and the core-to-L3 arbiter.
package core_l3_arbiter_pkg;
    localparam int NUM_CORES = 6;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int L3_CELLS  = 3600;
    localparam int CORE_ID_W = 3;
    localparam int ACC_W     = 16;

    // Pointer value that makes core 0 the first winner after reset.
    localparam logic [CORE_ID_W-1:0] LAST_GRANT_RST = CORE_ID_W'(NUM_CORES - 1);

    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(L3_CELLS);
    endfunction
endpackage

// File: rtl/core_l3_arbiter_if.sv
// Core request bus plus the single registered L3 request stream.
interface core_l3_arbiter_if;
    import core_l3_arbiter_pkg::*;

    logic [NUM_CORES-1:0]        req_valid;
    logic [NUM_CORES-1:0]        req_ready;
    logic [NUM_CORES-1:0]        req_we;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES*DATA_W-1:0] req_wdata;
    logic                        l3_valid;
    logic                        l3_ready;
    logic                        l3_we;
    logic [ADDR_W-1:0]           l3_addr;
    logic [DATA_W-1:0]           l3_wdata;
    logic [CORE_ID_W-1:0]        l3_core_id;
    logic [NUM_CORES-1:0]        err_pulse;
    logic [ACC_W-1:0]            acc_count;

    // Arbiter view.
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, l3_ready,
        output req_ready, l3_valid, l3_we, l3_addr, l3_wdata, l3_core_id,
               err_pulse, acc_count
    );

    // Cores + L3 view.
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, l3_ready,
        input  req_ready, l3_valid, l3_we, l3_addr, l3_wdata, l3_core_id,
               err_pulse, acc_count
    );
endinterface

// File: rtl/core_l3_arbiter_rr_pick.sv
// Rotate-priority picker: first requester after last_grant, wrapping over the cores.
module core_l3_arbiter_rr_pick
    import core_l3_arbiter_pkg::*;
(
    input  logic [NUM_CORES-1:0] req,
    input  logic [CORE_ID_W-1:0] last_grant,
    output logic [NUM_CORES-1:0] grant,
    output logic [CORE_ID_W-1:0] grant_idx,
    output logic                 any
);
    logic [CORE_ID_W-1:0] idx;

    // Scan from lowest to highest priority so the nearest requester overwrites last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int off = NUM_CORES; off >= 1; off--) begin
            idx = CORE_ID_W'((int'(last_grant) + off) % NUM_CORES);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_l3_arbiter.sv
// Round-robin arbiter from the six cores into the shared L3 grid; one registered
// request slot, out-of-range cell indices are consumed and flagged to the issuer.
module core_l3_arbiter
    import core_l3_arbiter_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    core_l3_arbiter_if.master bus
);
    logic                 slot_free;
    logic [NUM_CORES-1:0] cand;
    logic [NUM_CORES-1:0] grant;
    logic [CORE_ID_W-1:0] grant_idx;
    logic                 any_grant;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic                 win_we;
    logic                 win_legal;

    logic [CORE_ID_W-1:0] last_grant;
    logic                 l3_valid_q;
    logic                 l3_we_q;
    logic [ADDR_W-1:0]    l3_addr_q;
    logic [DATA_W-1:0]    l3_wdata_q;
    logic [CORE_ID_W-1:0] l3_core_id_q;
    logic [NUM_CORES-1:0] err_q;
    logic [ACC_W-1:0]     acc_q;

    assign slot_free = !l3_valid_q || bus.l3_ready;
    assign cand      = slot_free ? bus.req_valid : '0;

    core_l3_arbiter_rr_pick u_pick (
        .req        (cand),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (any_grant)
    );

    assign win_addr  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign win_wdata = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
    assign win_we    = bus.req_we[grant_idx];
    assign win_legal = addr_legal(win_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= LAST_GRANT_RST;
            l3_valid_q   <= 1'b0;
            l3_we_q      <= 1'b0;
            l3_addr_q    <= '0;
            l3_wdata_q   <= '0;
            l3_core_id_q <= '0;
            err_q        <= '0;
            acc_q        <= '0;
        end else begin
            err_q <= '0;
            if (any_grant) begin
                last_grant <= grant_idx;
                acc_q      <= acc_q + ACC_W'(1);
                if (win_legal) begin
                    l3_valid_q   <= 1'b1;
                    l3_we_q      <= win_we;
                    l3_addr_q    <= win_addr;
                    l3_wdata_q   <= win_wdata;
                    l3_core_id_q <= grant_idx;
                end else begin
                    // Dropped request: the slot was free, so it simply empties.
                    l3_valid_q <= 1'b0;
                    err_q      <= grant;
                end
            end else if (slot_free) begin
                l3_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.l3_valid   = l3_valid_q;
    assign bus.l3_we      = l3_we_q;
    assign bus.l3_addr    = l3_addr_q;
    assign bus.l3_wdata   = l3_wdata_q;
    assign bus.l3_core_id = l3_core_id_q;
    assign bus.err_pulse  = err_q;
    assign bus.acc_count  = acc_q;
endmodule

// File: doc/core_l3_arbiter.md
# core_l3_arbiter

Round-robin request arbiter between the six core datapath blocks and the shared central L3 grid (60×60 cells of 16 bits). It collects per-core valid/ready read/write requests, picks one per cycle fairly, range-checks the L3 cell index, and drives a single registered request stream into the L3. Out-of-range requests are consumed and flagged back to the issuing core rather than forwarded.

## Interface
Parameters:
- NUM_CORES, 6, number of requesting cores
- ADDR_W, 12, L3 cell index width; legal range 0..L3_CELLS-1
- DATA_W, 16, write data width (one L3 cell)
- L3_CELLS, 3600, number of valid L3 cells

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_CORES  per-core request valid
- req_ready  out  NUM_CORES  per-core accept; at most one bit high per cycle
- req_we  in  NUM_CORES  per-core write enable (1=write, 0=read)
- req_addr  in  NUM_CORES*ADDR_W  per-core cell index, core k at [k*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
- l3_valid  out  1  request to L3 valid
- l3_ready  in  1  L3 accepts request
- l3_we  out  1  forwarded write enable
- l3_addr  out  ADDR_W  forwarded cell index
- l3_wdata  out  DATA_W  forwarded write data
- l3_core_id  out  3  index of originating core
- err_pulse  out  NUM_CORES  one-cycle pulse: core's out-of-range request was dropped
- acc_count  out  16  total accepted requests (forwarded + dropped), wraps

## Operation
- Output slot: single register stage (l3_valid, l3_we, l3_addr, l3_wdata, l3_core_id). Slot "free" = !l3_valid || l3_ready.
- Arbitration runs only when slot free. Candidates = req_valid bits. Search order starts at last_grant+1, wrapping modulo NUM_CORES; first candidate wins.
- Winner k: req_ready[k]=1 combinationally same cycle; all others 0. No grant when slot not free (req_ready all 0).
- If winner's addr < L3_CELLS: slot loads winner's fields next edge, l3_valid=1.
- If addr >= L3_CELLS: request consumed, slot not loaded (l3_valid goes 0 if it was draining), err_pulse[k]=1 for exactly the next cycle.
- last_grant updates to k on every grant (forwarded or dropped); unchanged otherwise.
- acc_count increments by 1 on every grant, wraps 0xFFFF->0x0000.
- Slot drained with no winner: l3_valid->0.
- Held request: while l3_valid && !l3_ready, all l3_* outputs stable.
- Core holding req_valid without ready must keep its fields stable (upstream rule; not checked).

## Timing
- Reset values: l3_valid=0, l3_we=0, l3_addr=0, l3_wdata=0, l3_core_id=0, err_pulse=0, acc_count=0, last_grant=NUM_CORES-1 (core 0 wins first). req_ready is combinational and 0 while slot occupied/no requests.
- Latency: grant at cycle N -> l3_valid at N+1; err_pulse at N+1.
- Throughput: one grant per cycle when l3_ready held high (back-to-back, no bubble).
- Fairness: with all cores requesting continuously and l3_ready=1, grant order 0,1,2,3,4,5,0,… ; any requesting core waits ≤ NUM_CORES-1 grants.
- Simultaneous l3_ready and new grant: old slot retires and new one loads on same edge.
- Reset mid-operation: slot and pending err_pulse cleared immediately; in-flight request lost; pointer returns to NUM_CORES-1.

## Structure
- Shared package: NUM_CORES, L3_CELLS, ADDR_W, DATA_W, CORE_ID_W=3 constants used by cores, L3 grid and this block.
- Sub-module rr_pick: combinational rotate-priority picker (req vector, last_grant -> grant one-hot, grant index, any). Arbiter wraps it with slot register, range check, counters.

## Test plan
- Reset then all six req_valid=1, l3_ready=1, addrs 10..15 -> grants 0,1,2,3,4,5,0 on consecutive cycles; l3_addr follows one cycle later; acc_count=7 after 7 cycles.
- Core 2 addr=3600, core 3 addr=3599, both valid -> cycle 1 err_pulse[2]=1, no l3_valid for core 2; core 3 forwarded with l3_addr=3599, l3_core_id=3.
- l3_ready=0 for 5 cycles with slot full (core 1 write, wdata=0xBEEF) -> outputs stable, req_ready=0 throughout; release -> next core granted on same edge.
- Only core 4 requests, repeatedly -> granted every cycle (pointer wrap does not block sole requester).
- Assert rst_n low mid-burst with l3_valid=1 -> l3_valid=0 asynchronously; after release, core 0 wins first.
- 65536 grants -> acc_count wraps to 0x0000.
